obstacle_scroller: RTL and testbench
====================================

// Module: obstacle_scroller
// PURPOSE
//  Generates and scrolls the 3-lane obstacle field for the game. Five rows (obstacle0 = top/new,
//  obstacle4 = player row) shift down one row per scroll step; obstacle4 feeds the collision/score
//  block. The scroll rate speeds up over time on the same schedule as the score rate.
//  All scrolling and speed-up stop while game_over is high.
// PARAMETERS
//  START_TICKS_PER_STEP  100      fast_hz ticks per scroll step after reset
//  END_TICKS_PER_STEP    20       floor for ticks per step (fastest scroll)
//  TICKS_TO_SPEEDUP      750      ticks between successive decrements of ticks_per_step
//  SPAWN_THRESH          6        spawn when lfsr[7:4] < SPAWN_THRESH (0..16)
//  MIN_GAP               2        forced empty rows inserted after every non-empty row
//  LFSR_SEED             16'hACE1 LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//  fast_hz    in   1  game clock
//  rst        in   1  asynchronous, active-high reset
//  game_over  in   1  from collision/score block; freezes field and speed-up
//  obstacle0  out  3  top row, bit i = lane i blocked
//  obstacle1  out  3  row 1
//  obstacle2  out  3  row 2
//  obstacle3  out  3  row 3
//  obstacle4  out  3  player row, consumed by collision/score block
//  step       out  1  one-cycle pulse, high in the cycle after the edge that shifted the rows
// BEHAVIOUR
//  - Reset (async, immediate): obstacle0..4 = 0, step = 0, step_cnt = 0, speed_cnt = 0,
//    ticks_per_step = START_TICKS_PER_STEP, gap_cnt = 0, lfsr = LFSR_SEED (or 1 if seed = 0).
//  - LFSR: 16-bit Fibonacci, shift left, fb = l[15]^l[13]^l[12]^l[10]. Advances every
//    cycle out of reset, including during game_over. It is never 0.
//  - While game_over = 0, each edge:
//    - step_cnt increments. When step_cnt >= ticks_per_step-1: step_cnt <= 0, step <= 1, and
//      the shift happens: obstacle4<=obstacle3, 3<=2, 2<=1, 1<=0, obstacle0<=new_row.
//      Otherwise step <= 0.
//    - speed_cnt increments. When speed_cnt == TICKS_TO_SPEEDUP-1: speed_cnt <= 0, and
//      ticks_per_step decrements by 1 if it is > END_TICKS_PER_STEP. The comparison uses
//      '>=', so a shrink below the current step_cnt fires on the next edge with no wrap.
//  - new_row, computed from the current (pre-advance) lfsr:
//    - gap_cnt != 0: row = 000 and gap_cnt decrements.
//    - else if lfsr[7:4] < SPAWN_THRESH: row = cand, gap_cnt <= MIN_GAP, where
//      cand = lfsr[2:0], except 000 -> 010 and 111 -> 101.
//    - else: row = 000.
//    A row never blocks all three lanes, and at least MIN_GAP empty rows follow every
//    obstacle row.
//  - game_over = 1 at an edge: no shift, step <= 0, step_cnt and speed_cnt hold, rows hold.
//    Deasserting game_over resumes from the held counts. The game restarts only through rst.
//  - game_over rising in the same edge as a due step: the step is suppressed.
//  - Widths: counters are 32-bit unsigned; ticks_per_step is never below END_TICKS_PER_STEP.
// STRUCTURE
//  - Shared package/include game_pkg: LANES = 3, ROWS = 5, lane row type [LANES-1:0],
//    LFSR tap constants. The collision/score block uses the same package.
//  - Sub-module lfsr16 (seed param, clk, async rst, free-running q[15:0]).
//  - This module holds: step timer, speed-up timer, row generator, 5-row shift register.
// TESTING (bench uses START=10, END=4, TICKS_TO_SPEEDUP=30 unless noted)
//  1 Reset, game_over=0: all rows 000; first step pulse at cycle 10; with SPAWN_THRESH=16
//    and MIN_GAP=2, obstacle0 shows non-000 then 000,000 cyclically.
//  2 Shift check: force a known seed; after 5 steps, obstacle4 equals the row obstacle0 showed
//    4 steps earlier; every row is != 111 across 10k steps.
//  3 Speed-up: step intervals are 10,10,10 and then shrink by 1 every 30 ticks down to 4;
//    they stay at 4 after 300+ ticks.
//  4 Freeze: raise game_over on a step-due edge -> no shift, step stays 0, rows constant for
//    100 cycles; deassert -> next step after the remaining ticks.
//  5 Async rst mid-run (between clock edges): outputs clear immediately; ticks_per_step
//    back to 10.
//  6 SPAWN_THRESH=0 -> all rows stay 000 forever; LFSR_SEED=0 -> lfsr is never 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: lane/row geometry and LFSR taps shared by the obstacle and collision/score blocks
package game_pkg;
  localparam int LANES = 3;
  localparam int ROWS = 5;
  typedef logic [LANES-1:0] row_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR; a zero seed is replaced by 1 so it never locks up
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= INIT;
    else q <= lfsr_next(q);
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: 5-row, 3-lane obstacle field with random row generation,
// accelerating scroll rate and a game_over freeze
module obstacle_scroller
  import game_pkg::*;
#(
  parameter int unsigned   START_TICKS_PER_STEP = 100,
  parameter int unsigned   END_TICKS_PER_STEP   = 20,
  parameter int unsigned   TICKS_TO_SPEEDUP     = 750,
  parameter int unsigned   SPAWN_THRESH         = 6,
  parameter int unsigned   MIN_GAP              = 2,
  parameter logic [15:0]   LFSR_SEED            = 16'hACE1
) (
  input  logic             fast_hz,
  input  logic             rst,
  input  logic             game_over,
  output logic [LANES-1:0] obstacle0,
  output logic [LANES-1:0] obstacle1,
  output logic [LANES-1:0] obstacle2,
  output logic [LANES-1:0] obstacle3,
  output logic [LANES-1:0] obstacle4,
  output logic             step
);
  logic [15:0] lfsr_q;
  logic [ROWS-1:0][LANES-1:0] rows_q, rows_d;
  logic [31:0] step_cnt_q, step_cnt_d, speed_cnt_q, speed_cnt_d, tps_q, tps_d, gap_q, gap_d;
  logic step_q, step_d, due, wrap, spawn;
  row_t cand, new_row;
  logic unused_lfsr;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(fast_hz), .rst(rst), .q(lfsr_q));
  assign unused_lfsr = ^{lfsr_q[15:8], lfsr_q[3]};
  always_comb begin
    due = step_cnt_q >= tps_q - 32'd1;
    wrap = speed_cnt_q == TICKS_TO_SPEEDUP - 1;
    spawn = 32'(lfsr_q[7:4]) < SPAWN_THRESH;
    // a full-width block would be unwinnable, so both degenerate patterns are remapped
    cand = lfsr_q[2:0] == 3'b000 ? 3'b010 : lfsr_q[2:0] == 3'b111 ? 3'b101 : lfsr_q[2:0];
    new_row = (gap_q == 0 && spawn) ? cand : '0;
    step_cnt_d = step_cnt_q;
    speed_cnt_d = speed_cnt_q;
    tps_d = tps_q;
    gap_d = gap_q;
    rows_d = rows_q;
    step_d = 1'b0;
    if (!game_over) begin
      step_cnt_d = due ? '0 : step_cnt_q + 32'd1;
      speed_cnt_d = wrap ? '0 : speed_cnt_q + 32'd1;
      tps_d = (wrap && tps_q > END_TICKS_PER_STEP) ? tps_q - 32'd1 : tps_q;
      step_d = due;
      if (due) begin
        rows_d = {rows_q[ROWS-2:0], new_row};
        gap_d = gap_q != 0 ? gap_q - 32'd1 : spawn ? MIN_GAP : '0;
      end
    end
  end
  always_ff @(posedge fast_hz or posedge rst)
    if (rst) begin
      rows_q <= '0;
      step_q <= 1'b0;
      step_cnt_q <= '0;
      speed_cnt_q <= '0;
      tps_q <= START_TICKS_PER_STEP;
      gap_q <= '0;
    end else begin
      rows_q <= rows_d;
      step_q <= step_d;
      step_cnt_q <= step_cnt_d;
      speed_cnt_q <= speed_cnt_d;
      tps_q <= tps_d;
      gap_q <= gap_d;
    end
  assign obstacle0 = rows_q[0];
  assign obstacle1 = rows_q[1];
  assign obstacle2 = rows_q[2];
  assign obstacle3 = rows_q[3];
  assign obstacle4 = rows_q[4];
  assign step = step_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller: cycle-level reference model feeding a scoreboard, plus
// targeted checks on step timing, speed-up, freeze, async reset and spawn extremes
module tb_obstacle_scroller;
  localparam int unsigned ST = 10, EN = 4, TS = 30, SP = 6, MG = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  logic fast_hz, rst, go;
  logic [2:0] o0, o1, o2, o3, o4, f0, f1, f2, f3, f4, z0, z1, z2, z3, z4;
  logic st, fst, zst;
  int checks = 0, errors = 0, cyc = 0, nsteps = 0, fidx = 0;
  logic [15:0] m_lfsr;
  logic [2:0] m_rows [5];
  logic m_step;
  int unsigned m_scnt, m_spd, m_tps, m_gap;
  logic [15:0] exp_q [$];
  int step_t [$];
  logic [2:0] hist [$];
  obstacle_scroller #(.START_TICKS_PER_STEP(ST), .END_TICKS_PER_STEP(EN), .TICKS_TO_SPEEDUP(TS),
    .SPAWN_THRESH(SP), .MIN_GAP(MG), .LFSR_SEED(SEED)) dut (.fast_hz(fast_hz), .rst(rst),
    .game_over(go), .obstacle0(o0), .obstacle1(o1), .obstacle2(o2), .obstacle3(o3),
    .obstacle4(o4), .step(st));
  obstacle_scroller #(.START_TICKS_PER_STEP(ST), .END_TICKS_PER_STEP(EN), .TICKS_TO_SPEEDUP(TS),
    .SPAWN_THRESH(16), .MIN_GAP(2)) dut_f (.fast_hz(fast_hz), .rst(rst),
    .game_over(go), .obstacle0(f0), .obstacle1(f1), .obstacle2(f2), .obstacle3(f3),
    .obstacle4(f4), .step(fst));
  obstacle_scroller #(.START_TICKS_PER_STEP(ST), .END_TICKS_PER_STEP(EN), .TICKS_TO_SPEEDUP(TS),
    .SPAWN_THRESH(0), .MIN_GAP(MG), .LFSR_SEED(16'h0000)) dut_z (.fast_hz(fast_hz), .rst(rst),
    .game_over(go), .obstacle0(z0), .obstacle1(z1), .obstacle2(z2), .obstacle3(z3),
    .obstacle4(z4), .step(zst));
  initial fast_hz = 1'b0;
  always #5 fast_hz = ~fast_hz;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    m_lfsr = SEED;
    foreach (m_rows[i]) m_rows[i] = 3'b000;
    m_step = 1'b0;
    m_scnt = 0;
    m_spd = 0;
    m_tps = ST;
    m_gap = 0;
  endtask
  task automatic model_edge(input logic g);
    logic [15:0] l;
    logic [2:0] nr;
    bit due;
    l = m_lfsr;
    m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    m_step = 1'b0;
    if (g) return;
    due = m_scnt >= m_tps - 1;
    m_scnt = due ? 0 : m_scnt + 1;
    if (m_spd == TS - 1) begin
      m_spd = 0;
      if (m_tps > EN) m_tps--;
    end else m_spd++;
    if (!due) return;
    m_step = 1'b1;
    nr = 3'b000;
    if (m_gap > 0) m_gap--;
    else if (l[7:4] < SP) begin
      nr = l[2:0];
      if (nr == 3'b000) nr = 3'b010;
      else if (nr == 3'b111) nr = 3'b101;
      m_gap = MG;
    end
    for (int i = 4; i > 0; i--) m_rows[i] = m_rows[i-1];
    m_rows[0] = nr;
  endtask
  task automatic do_reset();
    model_reset();
    exp_q.delete();
    step_t.delete();
    hist.delete();
    cyc = 0;
    nsteps = 0;
    fidx = 0;
  endtask
  task automatic cycle();
    model_edge(go);
    exp_q.push_back({m_rows[4], m_rows[3], m_rows[2], m_rows[1], m_rows[0], m_step});
    @(posedge fast_hz);
    #1;
    cyc++;
    chk("rows_step", {o4, o3, o2, o1, o0, st}, exp_q.pop_front());
    if (st) begin
      step_t.push_back(cyc);
      nsteps++;
      hist.push_back(o0);
      chk("no111", o0 == 3'b111, 0);
      if (hist.size() >= 5) chk("shift4", o4, hist[hist.size()-5]);
    end
    if (fst) begin
      chk("spawn16", f0 != 3'b000, fidx % 3 == 0);
      fidx++;
    end
    if (zst) begin
      chk("zero_rows", {z4, z3, z2, z1, z0}, 0);
      chk("lfsr_nz", dut_z.lfsr_q != 16'h0000, 1);
    end
  endtask
  initial begin
    int n, n0;
    logic [14:0] snap;
    rst = 1'b1;
    go = 1'b0;
    repeat (2) @(posedge fast_hz);
    #1;
    chk("reset_out", {o4, o3, o2, o1, o0, st}, 0);
    chk("seed0_lfsr", dut_z.lfsr_q, 16'h0001);
    rst = 1'b0;
    do_reset();
    repeat (400) cycle();
    chk("nsteps_ok", step_t.size() >= 5, 1);
    if (step_t.size() >= 5) begin
      chk("first_step", step_t[0], 10);
      chk("interval1", step_t[1] - step_t[0], 10);
      chk("interval2", step_t[2] - step_t[1], 10);
      chk("interval3", step_t[3] - step_t[2], 9);
      chk("interval_floor", step_t[step_t.size()-1] - step_t[step_t.size()-2], 4);
    end
    n = 0;
    while (!(m_scnt >= m_tps - 1) && n < 50) begin
      cycle();
      n++;
    end
    chk("due_found", n < 50, 1);
    go = 1'b1;
    snap = {o4, o3, o2, o1, o0};
    n0 = nsteps;
    repeat (100) cycle();
    chk("frozen_rows", {o4, o3, o2, o1, o0}, snap);
    chk("frozen_steps", nsteps - n0, 0);
    go = 1'b0;
    cycle();
    chk("resume_step", st, 1);
    repeat (7) cycle();
    #4;
    rst = 1'b1;
    #1;
    chk("async_clear", {o4, o3, o2, o1, o0, st}, 0);
    @(posedge fast_hz);
    #1;
    rst = 1'b0;
    do_reset();
    repeat (10) cycle();
    chk("post_rst_step", step_t.size() > 0 ? step_t[0] : 0, 10);
    while (nsteps < 10000 && cyc < 60000) cycle();
    chk("long_steps", nsteps >= 10000, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
